if_pc_predictor: RTL and testbench
==================================

# if_pc_predictor

Fetch-side PC generator and predictor for the in-order pipeline. Holds the fetch PC, drives the instruction SRAM, and predicts each instruction's successor with a direct-mapped branch target buffer (BTB). It hands {PC, instruction, predicted next PC} to the decode stage, where the branch unit checks the prediction. On a branch unit cancel it redirects to the resolved target and trains the BTB.

## Interface
- BTB_ENTRIES, 16: BTB depth; power of two, ≥2.
- RESET_PC, 32'h1C00_0000: first fetch address after reset.

- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- inst_sram_en  out  1  read request this cycle.
- inst_sram_addr  out  32  read address; equals fetch_pc.
- inst_sram_rdata  in  32  read data, valid one cycle after request.
- id_allowin  in  1  decode stage can accept an instruction this cycle.
- if_to_id_valid  out  1  IF holds a valid instruction.
- if_pc  out  32  PC of the IF instruction.
- if_inst  out  32  IF instruction word.
- if_pred_pc  out  32  predicted next PC of the IF instruction (feeds the branch unit's pred_PC).
- br_taken_cancel  in  1  misprediction detected downstream.
- br_target  in  32  correct next PC; valid with br_taken_cancel.
- upd_valid  in  1  a branch resolved this cycle (train the BTB).
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  branch was taken.
- upd_target  in  32  taken target.

## Operation
- Index is pc[log2(BTB_ENTRIES)+1:2]. Tag is pc[31:log2(BTB_ENTRIES)+2]. Each entry holds valid, tag and target.
- Lookup is combinational on fetch_pc. On a hit, pred = target; otherwise pred = fetch_pc+4 (32-bit wrap: 32'hFFFF_FFFC+4 = 0).
- fetch_go = ~if_to_id_valid | id_allowin.
- inst_sram_en = ~reset & ~br_taken_cancel & fetch_go.
- Priority per cycle: reset > cancel > stall > advance.
  - Cancel: fetch_pc←br_target; if_to_id_valid←0, which discards the wrong-path IF instruction.
  - Advance (fetch_go): fetch_pc←pred; if_pc←fetch_pc; if_pred_pc←pred; if_to_id_valid←1.
  - Stall (~fetch_go): all registers hold.
- Instruction buffer:
  - If IF is valid and not accepted on the first cycle after the SRAM returns data, inst_sram_rdata is captured into inst_buf.
  - During the stall, if_inst = inst_buf; otherwise if_inst = inst_sram_rdata.
  - inst_buf is cleared on advance, cancel and reset.
- BTB update (upd_valid, written at the clock edge):
  - taken: entry←{1, tag(upd_pc), upd_target}.
  - not taken: clear valid if the tag matches; if the tag does not match, no change.
- A lookup and an update to the same index in the same cycle: the lookup sees the old contents.

## Timing
- Reset values: fetch_pc=RESET_PC; if_to_id_valid=0; if_pc=0; if_pred_pc=0; inst_buf=0; all BTB valid=0 (cleared in one cycle). inst_sram_en=0 while reset is asserted.
- Startup: the first cycle after reset deasserts, inst_sram_addr=RESET_PC with en=1. The next cycle, if_to_id_valid=1 and if_pc=RESET_PC.
- Fetch latency: one cycle from request to IF valid. Sustained throughput is one instruction per cycle when id_allowin=1.
- Redirect penalty: cancel in cycle t; cycle t+1 requests br_target; cycle t+2 has IF valid with if_pc=br_target.
- A cancel during a stall still redirects.
- A cancel together with an upd_valid trains the BTB and redirects in the same edge.
- Training latency: a BTB update is visible to a lookup one cycle after upd_valid.

## Configuration
- IF_PC_PRED_BHT_EN defined:
  - Each entry adds a 2-bit saturating counter. A hit predicts taken only if counter[1]=1.
  - On taken: a tag match increments the counter (saturating at 3); a mismatch or invalid entry allocates with counter=2.
  - On not taken: a match decrements the counter (saturating at 0) and keeps valid.
- Undefined: no counters; any hit predicts taken; behaviour is exactly as in Operation.

## Structure
- Shared package if_pred_pkg holds:
  - RESET_PC default;
  - index/tag width functions;
  - BTB entry typedef (valid, tag, target, optional counter);
  - counter encodings.
- Sub-module if_btb holds the storage, combinational lookup (hit, target) and the update write port. Fetch control, the IF register and inst_buf live in the top module.

## Test plan
- Reset then release, id_allowin=1, empty BTB → addresses 1C00_0000, 1C00_0004, 1C00_0008… on consecutive cycles; if_pred_pc = if_pc+4.
- upd_valid with pc=1C00_0010, taken, target=1C00_0100; then fetch 1C00_0010 → next address 1C00_0100; if_pred_pc=1C00_0100.
- br_taken_cancel with target=1C00_0200 while IF is valid → IF invalid next cycle; if_pc=1C00_0200 two cycles later; the wrong-path instruction never has valid=1.
- id_allowin=0 for 3 cycles while IF is valid → if_pc and if_inst stable and equal to the pre-stall values; sram_en=0; resumes without loss.
- Train pc=1C00_0010 not taken after taken → the entry is cleared (macro off); with IF_PC_PRED_BHT_EN, taken ×1 then not-taken ×1 → predicts +4.
- fetch_pc=FFFF_FFFC, BTB miss → next address 0000_0000.

Source files
------------

// File: rtl/if_pred_pkg.sv
// -----------------------------------------------------------------------------
// if_pred_pkg
// Shared definitions for the fetch-side PC predictor.
//   - RESET_PC_DEF : default first fetch address after reset
//   - idx_w/tag_w  : BTB index and tag widths for a given depth
//   - btb_entry_t  : one BTB entry (valid, tag, target, optional counter)
//   - CTR_*        : 2-bit saturating counter encodings
// Optional feature macro: IF_PC_PRED_BHT_EN adds a 2-bit counter per entry.
// -----------------------------------------------------------------------------
package if_pred_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1C00_0000;

  // Index covers pc[idx_w+1:2]; the tag is everything above it.
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int entries);
    return 30 - $clog2(entries);
  endfunction

  // Tag field is sized for the smallest legal BTB (2 entries); deeper BTBs
  // store their narrower tag zero-extended into it.
  localparam int TAG_MAX_W = tag_w(2);

  localparam logic [1:0] CTR_SNT = 2'd0;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'd1;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'd2;  // weakly taken (allocation value)
  localparam logic [1:0] CTR_ST  = 2'd3;  // strongly taken

  typedef struct packed {
    logic                 valid;
`ifdef IF_PC_PRED_BHT_EN
    logic [1:0]           ctr;
`endif
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

endpackage

// File: rtl/if_pc_predictor_if.sv
// -----------------------------------------------------------------------------
// if_pc_predictor_if
// Bus bundle between the IF-stage predictor and its surroundings
// (instruction SRAM, decode stage, branch unit).
//   master : the predictor (drives SRAM request and the IF->ID outputs)
//   slave  : the environment (SRAM data, decode back-pressure, branch
//            cancel/redirect and BTB training)
// -----------------------------------------------------------------------------
interface if_pc_predictor_if;

  // instruction SRAM
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;

  // IF -> ID
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_pred_pc;

  // branch unit redirect
  logic        br_taken_cancel;
  logic [31:0] br_target;

  // BTB training
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  modport master (
    output inst_sram_en, inst_sram_addr,
    input  inst_sram_rdata,
    input  id_allowin,
    output if_to_id_valid, if_pc, if_inst, if_pred_pc,
    input  br_taken_cancel, br_target,
    input  upd_valid, upd_pc, upd_taken, upd_target
  );

  modport slave (
    input  inst_sram_en, inst_sram_addr,
    output inst_sram_rdata,
    output id_allowin,
    input  if_to_id_valid, if_pc, if_inst, if_pred_pc,
    output br_taken_cancel, br_target,
    output upd_valid, upd_pc, upd_taken, upd_target
  );

endinterface

// File: rtl/if_btb.sv
// -----------------------------------------------------------------------------
// if_btb
// Direct-mapped branch target buffer: storage, combinational lookup and one
// training write port.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears all entries)
//   i_lkp_pc        : lookup address (current fetch PC)
//   o_hit           : lookup hit that predicts taken
//   o_target        : stored target of the indexed entry
//   i_upd_*         : training write (valid, branch PC, taken, taken target)
// Optional feature macro: IF_PC_PRED_BHT_EN -- each entry carries a 2-bit
// saturating counter and only predicts taken when counter[1] is set.
// -----------------------------------------------------------------------------
module if_btb
  import if_pred_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_lkp_pc,
  output logic        o_hit,
  output logic [31:0] o_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target
);

  localparam int IW = idx_w(ENTRIES);

  btb_entry_t           r_btb [ENTRIES];

  logic [IW-1:0]        w_lkp_idx;
  logic [TAG_MAX_W-1:0] w_lkp_tag;
  btb_entry_t           w_lkp_entry;
  logic                 w_lkp_match;

  logic [IW-1:0]        w_upd_idx;
  logic [TAG_MAX_W-1:0] w_upd_tag;
  btb_entry_t           w_upd_entry;
  logic                 w_upd_match;
  btb_entry_t           w_new_entry;

  // Lookup reads the registered array, so a same-cycle update to the same
  // index is only seen from the next cycle on.
  assign w_lkp_idx   = IW'(i_lkp_pc >> 2);
  assign w_lkp_tag   = TAG_MAX_W'(i_lkp_pc >> (IW + 2));
  assign w_lkp_entry = r_btb[w_lkp_idx];
  assign w_lkp_match = w_lkp_entry.valid && (w_lkp_entry.tag == w_lkp_tag);

`ifdef IF_PC_PRED_BHT_EN
  assign o_hit = w_lkp_match && w_lkp_entry.ctr[1];
`else
  assign o_hit = w_lkp_match;
`endif
  assign o_target = w_lkp_entry.target;

  assign w_upd_idx   = IW'(i_upd_pc >> 2);
  assign w_upd_tag   = TAG_MAX_W'(i_upd_pc >> (IW + 2));
  assign w_upd_entry = r_btb[w_upd_idx];
  assign w_upd_match = w_upd_entry.valid && (w_upd_entry.tag == w_upd_tag);

  // Entry written when a taken branch allocates (replaces whatever was there).
  always_comb begin
    w_new_entry        = '0;
    w_new_entry.valid  = 1'b1;
    w_new_entry.tag    = w_upd_tag;
    w_new_entry.target = i_upd_target;
`ifdef IF_PC_PRED_BHT_EN
    w_new_entry.ctr    = CTR_WT;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb[i] <= '0;
      end
    end else if (i_upd_valid) begin
      if (i_upd_taken) begin
`ifdef IF_PC_PRED_BHT_EN
        if (w_upd_match) begin
          if (w_upd_entry.ctr != CTR_ST) begin
            r_btb[w_upd_idx].ctr <= w_upd_entry.ctr + 2'd1;
          end
        end else begin
          r_btb[w_upd_idx] <= w_new_entry;
        end
`else
        r_btb[w_upd_idx] <= w_new_entry;
`endif
      end else if (w_upd_match) begin
        // A non-matching not-taken branch leaves the other branch's entry alone.
`ifdef IF_PC_PRED_BHT_EN
        if (w_upd_entry.ctr != CTR_SNT) begin
          r_btb[w_upd_idx].ctr <= w_upd_entry.ctr - 2'd1;
        end
`else
        r_btb[w_upd_idx].valid <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/if_pc_predictor.sv
// -----------------------------------------------------------------------------
// if_pc_predictor
// Fetch-side PC generator and predictor. Holds the fetch PC, requests the
// instruction SRAM, predicts the successor through if_btb and presents
// {PC, instruction, predicted next PC} to decode. A branch-unit cancel
// redirects fetch to br_target and drops the wrong-path IF instruction.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : if_pc_predictor_if.master (SRAM request/data, IF->ID handshake
//           and payload, branch redirect, BTB training)
// Parameters: BTB_ENTRIES (power of two, >= 2), RESET_PC.
// Optional feature macro: IF_PC_PRED_BHT_EN (2-bit counters in the BTB).
// -----------------------------------------------------------------------------
module if_pc_predictor
  import if_pred_pkg::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  if_pc_predictor_if.master   bus
);

  logic [31:0] r_fetch_pc;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pred_pc;
  logic [31:0] r_inst_buf;
  logic        r_buf_valid;

  logic        w_fetch_go;
  logic        w_btb_hit;
  logic [31:0] w_btb_target;
  logic [31:0] w_pred_pc;

  if_btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .reset        (reset),
    .i_lkp_pc     (r_fetch_pc),
    .o_hit        (w_btb_hit),
    .o_target     (w_btb_target),
    .i_upd_valid  (bus.upd_valid),
    .i_upd_pc     (bus.upd_pc),
    .i_upd_taken  (bus.upd_taken),
    .i_upd_target (bus.upd_target)
  );

  // Sequential fallback wraps naturally at 32 bits.
  assign w_pred_pc  = w_btb_hit ? w_btb_target : (r_fetch_pc + 32'd4);
  assign w_fetch_go = ~r_if_valid | bus.id_allowin;

  assign bus.inst_sram_en   = ~reset & ~bus.br_taken_cancel & w_fetch_go;
  assign bus.inst_sram_addr = r_fetch_pc;

  assign bus.if_to_id_valid = r_if_valid;
  assign bus.if_pc          = r_if_pc;
  assign bus.if_pred_pc     = r_if_pred_pc;
  // SRAM data is only guaranteed the cycle after the request; once a stall
  // has captured it, the buffer is the source until the next advance.
  assign bus.if_inst        = r_buf_valid ? r_inst_buf : bus.inst_sram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc   <= RESET_PC;
      r_if_valid   <= 1'b0;
      r_if_pc      <= 32'd0;
      r_if_pred_pc <= 32'd0;
      r_inst_buf   <= 32'd0;
      r_buf_valid  <= 1'b0;
    end else if (bus.br_taken_cancel) begin
      r_fetch_pc   <= bus.br_target;
      r_if_valid   <= 1'b0;
      r_inst_buf   <= 32'd0;
      r_buf_valid  <= 1'b0;
    end else if (w_fetch_go) begin
      r_fetch_pc   <= w_pred_pc;
      r_if_valid   <= 1'b1;
      r_if_pc      <= r_fetch_pc;
      r_if_pred_pc <= w_pred_pc;
      r_inst_buf   <= 32'd0;
      r_buf_valid  <= 1'b0;
    end else if (!r_buf_valid) begin
      // First stalled cycle: SRAM data is still the live response.
      r_inst_buf   <= bus.inst_sram_rdata;
      r_buf_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_pc_predictor.sv
module tb_if_pc_predictor;

  localparam int          ENT    = 16;
  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_pc_predictor_if bus();

  if_pc_predictor #(
    .BTB_ENTRIES (ENT),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pred;
  } if_exp_t;

  typedef struct {
    logic        en;
    logic        chk_addr;
    logic [31:0] addr;
  } rq_exp_t;

  if_exp_t if_q[$];
  rq_exp_t rq_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM environment: remembers last cycle's request to return data.
  logic        s_en   = 1'b0;
  logic [31:0] s_addr = 32'd0;
  always @(negedge clk) begin
    s_en   = bus.inst_sram_en;
    s_addr = bus.inst_sram_addr;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_fetch;
  bit          m_if_v;
  logic [31:0] m_if_pc, m_if_pred;
  bit          bv   [ENT];
  logic [31:0] btag [ENT];
  logic [31:0] btgt [ENT];
  int          bctr [ENT];

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(ENT));
  endfunction

  function automatic logic [31:0] m_tag(input logic [31:0] pc);
    return pc / (32'd4 * 32'(ENT));
  endfunction

  function automatic logic [31:0] m_pred(input logic [31:0] pc);
    int i;
    bit t;
    i = m_idx(pc);
    t = bv[i] && (btag[i] == m_tag(pc));
`ifdef IF_PC_PRED_BHT_EN
    t = t && (bctr[i] >= 2);
`endif
    return t ? btgt[i] : pc + 32'd4;
  endfunction

  task automatic m_train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    int i;
    bit match;
    i = m_idx(pc);
    match = bv[i] && (btag[i] == m_tag(pc));
    if (taken) begin
`ifdef IF_PC_PRED_BHT_EN
      if (match) begin
        if (bctr[i] < 3) bctr[i] = bctr[i] + 1;
      end else begin
        bv[i] = 1; btag[i] = m_tag(pc); btgt[i] = tgt; bctr[i] = 2;
      end
`else
      bv[i] = 1; btag[i] = m_tag(pc); btgt[i] = tgt;
`endif
    end else if (match) begin
`ifdef IF_PC_PRED_BHT_EN
      if (bctr[i] > 0) bctr[i] = bctr[i] - 1;
`else
      bv[i] = 0;
`endif
    end
  endtask

  task automatic m_reset();
    m_fetch = RST_PC; m_if_v = 0; m_if_pc = 32'd0; m_if_pred = 32'd0;
    for (int i = 0; i < ENT; i++) begin
      bv[i] = 0; btag[i] = 32'd0; btgt[i] = 32'd0; bctr[i] = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      rq_exp_t r;
      if_exp_t e;
      if (rq_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL req_queue_empty cyc=%0d", cyc);
      end else begin
        r = rq_q.pop_front();
        chk32("sram_en", 32'(bus.inst_sram_en), 32'(r.en));
        if (r.chk_addr) chk32("sram_addr", bus.inst_sram_addr, r.addr);
      end
      if (bus.if_to_id_valid) begin
        if (if_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_if_valid cyc=%0d actual_pc=%h", cyc, bus.if_pc);
        end else begin
          e = if_q.pop_front();
          chk32("if_valid_cycle", 32'(cyc), 32'(e.cyc));
          chk32("if_pc", bus.if_pc, e.pc);
          chk32("if_inst", bus.if_inst, e.inst);
          chk32("if_pred_pc", bus.if_pred_pc, e.pred);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit rst, input bit allow, input bit cancel, input logic [31:0] tgt,
                      input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
    bit          go;
    if_exp_t     ie;
    rq_exp_t     re;
    logic [31:0] p;
    @(posedge clk);
    #1;
    reset               = rst;
    bus.id_allowin      = allow;
    bus.br_taken_cancel = cancel;
    bus.br_target       = tgt;
    bus.upd_valid       = uv;
    bus.upd_pc          = upc;
    bus.upd_taken       = ut;
    bus.upd_target      = utgt;
    bus.inst_sram_rdata = s_en ? mem_word(s_addr) : $urandom;

    go          = !m_if_v || allow;
    re.en       = !rst && !cancel && go;
    re.chk_addr = !rst;
    re.addr     = m_fetch;
    rq_q.push_back(re);
    if (m_if_v) begin
      ie.cyc  = cyc;
      ie.pc   = m_if_pc;
      ie.inst = mem_word(m_if_pc);
      ie.pred = m_if_pred;
      if_q.push_back(ie);
    end
    mon_en = 1;

    if (rst) begin
      m_reset();
    end else begin
      if (cancel) begin
        m_fetch = tgt; m_if_v = 0;
      end else if (go) begin
        p = m_pred(m_fetch);
        m_if_pc = m_fetch; m_if_pred = p; m_fetch = p; m_if_v = 1;
      end
      if (uv) m_train(upc, ut, utgt);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 32'd0, 0, 32'd0, 0, 32'd0);
  endtask

  task automatic cancel_to(input logic [31:0] t);
    step(0, 1, 1, t, 0, 32'd0, 0, 32'd0);
  endtask

  function automatic logic [31:0] rnd_pc();
    return 32'h1C00_0000 + 32'($urandom_range(0, 63)) * 32'd4;
  endfunction

  initial begin
    reset = 1'b1;
    bus.id_allowin = 0; bus.br_taken_cancel = 0; bus.br_target = 0;
    bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_taken = 0; bus.upd_target = 0;
    bus.inst_sram_rdata = 0;
    m_reset();
    repeat (3) @(posedge clk);

    step(1, 1, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    step(0, 1, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    @(negedge clk);
    #1;
    chk32("rst_if_valid", 32'(bus.if_to_id_valid), 32'd0);
    chk32("rst_if_pc", bus.if_pc, 32'd0);
    chk32("rst_if_pred_pc", bus.if_pred_pc, 32'd0);
    chk32("first_addr", bus.inst_sram_addr, RST_PC);
    idle(6);

    // train 1C00_0010 -> 1C00_0100 in the same edge as a redirect
    step(0, 1, 1, 32'h1C00_0008, 1, 32'h1C00_0010, 1, 32'h1C00_0100);
    idle(8);

    // redirect while IF holds a valid instruction
    cancel_to(32'h1C00_0200);
    idle(5);

    // three-cycle decode stall
    repeat (3) step(0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    idle(4);

    // not taken after taken
    step(0, 1, 1, 32'h1C00_0008, 1, 32'h1C00_0010, 0, 32'd0);
    idle(6);

    // 32-bit wrap on a BTB miss
    cancel_to(32'hFFFF_FFF8);
    idle(5);

    // cancel during a stall
    step(0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    step(0, 0, 1, 32'h1C00_0040, 0, 32'd0, 0, 32'd0);
    idle(4);

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, rnd_pc(),
           $urandom_range(0, 2) == 0, rnd_pc(),
           $urandom_range(0, 3) != 0, rnd_pc());
    end
    idle(3);

    @(negedge clk);
    #1;
    mon_en = 0;
    chk32("if_queue_drained", 32'(if_q.size()), 32'd0);
    chk32("req_queue_drained", 32'(rq_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
